// File: rtl/mips_tlb_pkg.sv
// Shared definitions for the MIPS-style TLB responder.
// Holds the entry field widths, the uncached attribute code, the FSM state
// encodings, the probe miss value, the stored entry payload and the
// VPN2/ASID/G match rule used by both the lookup and the probe paths.
package mips_tlb_pkg;

  localparam int unsigned VPN2_W = 19;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned PFN_W  = 20;
  localparam int unsigned C_W    = 3;

  localparam logic [C_W-1:0] C_UNCACHED = 3'b010;
  localparam logic [31:0]    PROBE_MISS = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } tlb_state_e;

  // Non-reset part of an entry; V0/V1/G live in separately reset vectors.
  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic [PFN_W-1:0]  pfn0;
    logic [C_W-1:0]    c0;
    logic              d0;
    logic [PFN_W-1:0]  pfn1;
    logic [C_W-1:0]    c1;
    logic              d1;
  } tlb_data_t;

  // An entry matches on equal VPN2 and either a global entry or equal ASID.
  function automatic logic tlb_match(input logic [VPN2_W-1:0] e_vpn2,
                                     input logic [ASID_W-1:0] e_asid,
                                     input logic              e_g,
                                     input logic [VPN2_W-1:0] q_vpn2,
                                     input logic [ASID_W-1:0] q_asid);
    return (e_vpn2 == q_vpn2) && (e_g || (e_asid == q_asid));
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// Compares one TLB entry against a query VPN2/ASID.
// Ports: i_entry_vpn2/i_entry_asid/i_entry_g - stored entry tag fields
//        i_vpn2/i_asid                       - query tag
//        o_hit_c                             - combinational match bit
module tlb_entry_match
  import mips_tlb_pkg::*;
(
  input  logic [VPN2_W-1:0] i_entry_vpn2,
  input  logic [ASID_W-1:0] i_entry_asid,
  input  logic              i_entry_g,
  input  logic [VPN2_W-1:0] i_vpn2,
  input  logic [ASID_W-1:0] i_asid,
  output logic              o_hit_c
);

  assign o_hit_c = tlb_match(i_entry_vpn2, i_entry_asid, i_entry_g, i_vpn2, i_asid);

endmodule

// File: rtl/tlb_responder.sv
// Fully-associative MIPS-style TLB with a valid/ready translation port.
// A request is accepted in IDLE, compared against every entry in LOOKUP,
// and the registered result is presented in RESP until resp_ready.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_*                         - translation request (vaddr, asid, store)
//   resp_*                        - translation response and fault flags
//   wr_*                          - indexed entry write (EntryHi/EntryLo0/1)
//   probe_en/entryhi/result       - same-cycle probe, only with TLB_PROBE_EN
// Build option: define TLB_PROBE_EN to include the probe port and logic.
module tlb_responder
  import mips_tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_vaddr,
  input  logic [7:0]                 req_asid,
  input  logic                       req_store,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [31:0]                resp_paddr,
  output logic                       resp_uncached,
  output logic                       resp_miss,
  output logic                       resp_invalid,
  output logic                       resp_modified,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_index,
  input  logic [31:0]                wr_entryhi,
  input  logic [31:0]                wr_entrylo0,
  input  logic [31:0]                wr_entrylo1
`ifdef TLB_PROBE_EN
  ,
  input  logic                       probe_en,
  input  logic [31:0]                probe_entryhi,
  output logic [31:0]                probe_result
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  tlb_state_e r_state;
  logic       r_req_ready;
  logic [31:0] r_vaddr;
  logic [7:0]  r_asid;
  logic        r_store;

  logic        r_resp_valid;
  logic [31:0] r_resp_paddr;
  logic        r_resp_uncached;
  logic        r_resp_miss;
  logic        r_resp_invalid;
  logic        r_resp_modified;

  tlb_data_t          r_data [ENTRIES];
  logic [ENTRIES-1:0] r_v0;
  logic [ENTRIES-1:0] r_v1;
  logic [ENTRIES-1:0] r_g;

  logic [ENTRIES-1:0] w_hit;
  logic               w_any;
  logic [IDX_W-1:0]   w_idx;
  logic [PFN_W-1:0]   w_pfn;
  logic [C_W-1:0]     w_c;
  logic               w_d;
  logic               w_v;
  logic               w_miss;
  logic               w_invalid;
  logic               w_modified;
  logic               w_fault;
  logic [31:0]        w_paddr;
  logic               w_uncached;

  // EntryHi bits [12:8] and EntryLo bits [31:26] carry nothing for this TLB.
  logic w_unused_bits;
  assign w_unused_bits = ^{wr_entryhi[12:8], wr_entrylo0[31:26], wr_entrylo1[31:26]};

  // Valid and global bits are the only entry state cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= '0;
      r_v1 <= '0;
      r_g  <= '0;
    end else if (wr_en) begin
      r_v0[wr_index] <= wr_entrylo0[1];
      r_v1[wr_index] <= wr_entrylo1[1];
      r_g[wr_index]  <= wr_entrylo0[0] & wr_entrylo1[0];
    end
  end

  // Tag and page fields; a same-cycle LOOKUP sees the old values.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[wr_index] <= '{vpn2: wr_entryhi[31:13],
                            asid: wr_entryhi[7:0],
                            pfn0: wr_entrylo0[25:6],
                            c0:   wr_entrylo0[5:3],
                            d0:   wr_entrylo0[2],
                            pfn1: wr_entrylo1[25:6],
                            c1:   wr_entrylo1[5:3],
                            d1:   wr_entrylo1[2]};
    end
  end

  // One comparator per entry against the latched request.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_match
    tlb_entry_match u_match (
      .i_entry_vpn2 (r_data[g].vpn2),
      .i_entry_asid (r_data[g].asid),
      .i_entry_g    (r_g[g]),
      .i_vpn2       (r_vaddr[31:13]),
      .i_asid       (r_asid),
      .o_hit_c      (w_hit[g])
    );
  end

  // Lowest-index hit wins: scan downwards so the last assignment is lowest.
  always_comb begin
    w_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_idx = IDX_W'(i);
    end
  end

  // Page half selection, fault priority and physical address formation.
  always_comb begin
    w_any      = |w_hit;
    w_pfn      = r_vaddr[12] ? r_data[w_idx].pfn1 : r_data[w_idx].pfn0;
    w_c        = r_vaddr[12] ? r_data[w_idx].c1   : r_data[w_idx].c0;
    w_d        = r_vaddr[12] ? r_data[w_idx].d1   : r_data[w_idx].d0;
    w_v        = r_vaddr[12] ? r_v1[w_idx]        : r_v0[w_idx];
    w_miss     = ~w_any;
    w_invalid  = w_any & ~w_v;
    w_modified = w_any & w_v & r_store & ~w_d;
    w_fault    = w_miss | w_invalid | w_modified;
    w_paddr    = w_fault ? 32'h0 : {w_pfn, r_vaddr[11:0]};
    w_uncached = ~w_fault & (w_c == C_UNCACHED);
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_req_ready     <= 1'b0;
      r_vaddr         <= '0;
      r_asid          <= '0;
      r_store         <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_paddr    <= '0;
      r_resp_uncached <= 1'b0;
      r_resp_miss     <= 1'b0;
      r_resp_invalid  <= 1'b0;
      r_resp_modified <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_vaddr     <= req_vaddr;
            r_asid      <= req_asid;
            r_store     <= req_store;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOOKUP;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          r_resp_valid    <= 1'b1;
          r_resp_paddr    <= w_paddr;
          r_resp_uncached <= w_uncached;
          r_resp_miss     <= w_miss;
          r_resp_invalid  <= w_invalid;
          r_resp_modified <= w_modified;
          r_state         <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid    <= 1'b0;
            r_resp_paddr    <= '0;
            r_resp_uncached <= 1'b0;
            r_resp_miss     <= 1'b0;
            r_resp_invalid  <= 1'b0;
            r_resp_modified <= 1'b0;
            r_req_ready     <= 1'b1;
            r_state         <= ST_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_paddr    = r_resp_paddr;
  assign resp_uncached = r_resp_uncached;
  assign resp_miss     = r_resp_miss;
  assign resp_invalid  = r_resp_invalid;
  assign resp_modified = r_resp_modified;

`ifdef TLB_PROBE_EN
  logic [ENTRIES-1:0] w_probe_hit;
  logic [IDX_W-1:0]   w_probe_idx;
  logic               w_probe_unused_bits;

  assign w_probe_unused_bits = ^probe_entryhi[12:8];

  // Same-cycle probe against current contents, lowest matching index.
  always_comb begin
    w_probe_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_probe_hit[i] = tlb_match(r_data[i].vpn2, r_data[i].asid, r_g[i],
                                 probe_entryhi[31:13], probe_entryhi[7:0]);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_probe_hit[i]) w_probe_idx = IDX_W'(i);
    end
    if (!probe_en)         probe_result = 32'h0;
    else if (|w_probe_hit) probe_result = 32'(w_probe_idx);
    else                   probe_result = PROBE_MISS;
  end
`endif

endmodule
